trace_buffer: RTL and testbench
===============================

TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of trace entries (power of two).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port arm  input  1  one-cycle pulse that arms the trigger.
REQ-005 SHALL have port trig_pc  input  8  PC value that starts capture.
REQ-006 SHALL have port cap_len  input  5  number of entries to capture after trigger; 0 = unlimited.
REQ-007 SHALL have port clear  input  1  synchronous flush of buffer, flags and state.
REQ-008 SHALL have port pc  input  8  CPU program counter of the current cycle.
REQ-009 SHALL have port instr  input  8  CPU instruction of the current cycle.
REQ-010 SHALL have port reg_write  input  1  CPU register-write strobe; qualifies a trace event.
REQ-011 SHALL have port result  input  8  CPU write-back value.
REQ-012 SHALL have port rd_ready  input  1  host accepts the head entry.
REQ-013 SHALL have port rd_valid  output  1  head entry present (buffer not empty).
REQ-014 SHALL have port rd_data  output  24  head entry {pc, instr, result}.
REQ-015 SHALL have port count  output  log2(DEPTH)+1  occupancy.
REQ-016 SHALL have port full, empty  output  1 each  occupancy flags.
REQ-017 SHALL have port overflow  output  1  sticky: an event was dropped.
REQ-018 SHALL have port state  output  2  FSM state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.

Function
REQ-019 Event SHALL be a cycle with reg_write=1 while state is CAPTURE, or ARMED with pc==trig_pc.
REQ-020 FSM: IDLE -arm-> ARMED; ARMED -(pc==trig_pc)-> CAPTURE next cycle; CAPTURE -(captured==cap_len, cap_len!=0)-> DONE; DONE -arm-> ARMED; arm in ARMED/CAPTURE SHALL be ignored.
REQ-021 Trigger cycle itself SHALL be an event if reg_write=1 and SHALL count toward cap_len.
REQ-022 Capture counter SHALL reset to 0 on entry to ARMED; it counts pushes accepted, not dropped events.
REQ-023 Push SHALL write {pc,instr,result} at tail; entry visible on rd_data the following cycle.
REQ-024 Pop SHALL occur when rd_valid && rd_ready; head advances at that edge.
REQ-025 rd_data SHALL show the head entry whenever rd_valid=1; value undefined-free (holds last) when empty.
REQ-026 Event when full and no pop SHALL be dropped; overflow set to 1 next cycle; drops do not count toward cap_len.
REQ-027 Event when full with simultaneous pop SHALL be accepted; count unchanged.
REQ-028 Event when empty SHALL NOT bypass; rd_valid rises one cycle after the push.
REQ-029 Pointers SHALL wrap modulo DEPTH; count in 0..DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-030 clear SHALL take priority over arm, push and pop: empties buffer, clears overflow, returns FSM to IDLE.
REQ-031 Occupancy and FSM SHALL be unaffected by reg_write in IDLE and DONE; reading continues in all states.

Reset
REQ-032 On reset=0 at a clk edge: state=IDLE, count=0, empty=1, full=0, rd_valid=0, overflow=0, rd_data=0, pointers and capture counter 0.
REQ-033 Reset mid-capture SHALL discard all stored entries; arm SHALL be required again to resume.

Verification
REQ-034 arm, trig_pc=0x04, cap_len=3; reg_write every cycle, pc=0x00..0x09 -> entries pc 04,05,06 stored, state DONE, count=3.
REQ-035 cap_len=0, rd_ready=0, 20 events after trigger -> count=16, full=1, overflow=1, rd_data pc = first captured pc.
REQ-036 Full buffer, event and rd_ready=1 same cycle -> count stays 16, overflow stays 0, newest entry at tail.
REQ-037 Empty buffer, single event {0x10,0xA5,0x3C} -> rd_valid=1 next cycle, rd_data=0x10A53C; pop -> empty=1.
REQ-038 clear asserted with event and pop in CAPTURE -> next cycle count=0, overflow=0, state=IDLE.
REQ-039 reset=0 for one cycle with count=7 in CAPTURE -> all REQ-032 values; later reg_write without arm stores nothing.

Source files
------------

// File: rtl/trace_buffer_if.sv
// rtl/trace_buffer_if.sv - CPU trace-event inputs and host read port of the trace buffer
interface trace_buffer_if;
  logic [7:0]  pc;
  logic [7:0]  instr;
  logic        reg_write;
  logic [7:0]  result;
  logic        rd_ready;
  logic        rd_valid;
  logic [23:0] rd_data;

  modport master (
    output pc, instr, reg_write, result, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  pc, instr, reg_write, result, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/trace_buffer.sv
// rtl/trace_buffer.sv - triggered CPU trace capture FIFO with arm/capture/done control
module trace_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic [7:0]               trig_pc,
  input  logic [4:0]               cap_len,
  input  logic                     clear,
  trace_buffer_if.slave            bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [1:0]               state
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state_q;
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic [4:0]    captured;

  logic          trig_hit;
  logic          cap_open;
  logic          trace_event;
  logic          pop;
  logic          push;
  logic          drop;
  logic [4:0]    captured_next;

  // Once cap_len pushes are in, the rest of the CAPTURE cycle no longer qualifies events.
  always_comb begin
    trig_hit      = (state_q == ARMED) && (bus.pc == trig_pc);
    cap_open      = (state_q == CAPTURE) && ((cap_len == 5'd0) || (captured < cap_len));
    trace_event   = bus.reg_write && (trig_hit || cap_open);
    pop           = (count_q != '0) && bus.rd_ready;
    push          = trace_event && ((count_q != (AW+1)'(DEPTH)) || pop);
    drop          = trace_event && !push;
    captured_next = captured + 5'(push);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      captured   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      captured   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {bus.pc, bus.instr, bus.result};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count_q  <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) overflow_q <= 1'b1;
      captured <= captured_next;
      case (state_q)
        IDLE, DONE: if (arm) begin
          state_q  <= ARMED;
          captured <= '0;
        end
        ARMED:   if (trig_hit) state_q <= CAPTURE;
        CAPTURE: if ((cap_len != 5'd0) && (captured_next >= cap_len)) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count        = count_q;
  assign full         = (count_q == (AW+1)'(DEPTH));
  assign empty        = (count_q == '0);
  assign overflow     = overflow_q;
  assign state        = state_q;
  assign bus.rd_valid = (count_q != '0);
  assign bus.rd_data  = mem[rd_ptr];
endmodule

// File: tb/tb_trace_buffer.sv
// tb/tb_trace_buffer.sv - directed and randomized checks of trace_buffer against a queue model
module tb_trace_buffer;
  localparam int DEPTH = 16;

  logic       clk;
  logic       reset;
  logic       arm;
  logic [7:0] trig_pc;
  logic [4:0] cap_len;
  logic       clear;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [1:0] state;

  trace_buffer_if bus ();

  trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .arm      (arm),
    .trig_pc  (trig_pc),
    .cap_len  (cap_len),
    .clear    (clear),
    .bus      (bus.slave),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .state    (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: a plain queue of captured entries plus the capture rules.
  logic [23:0] q[$];
  int          m_state;
  int          m_cap;
  bit          m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit do_pop, trig, open, ev;
    if (!reset) begin
      q.delete();
      m_state = 0;
      m_ovf   = 0;
      m_cap   = 0;
    end else if (clear) begin
      q.delete();
      m_state = 0;
      m_ovf   = 0;
    end else begin
      do_pop = (q.size() > 0) && bus.rd_ready;
      trig   = (m_state == 1) && (bus.pc == trig_pc);
      open   = (m_state == 2) && (cap_len == 0 || m_cap < int'(cap_len));
      ev     = bus.reg_write && (trig || open);
      if (do_pop) void'(q.pop_front());
      if (ev) begin
        if (q.size() < DEPTH) begin
          q.push_back({bus.pc, bus.instr, bus.result});
          m_cap++;
        end else begin
          m_ovf = 1;
        end
      end
      case (m_state)
        0, 3: if (arm) begin m_state = 1; m_cap = 0; end
        1: if (trig) m_state = 2;
        2: if (cap_len != 0 && m_cap >= int'(cap_len)) m_state = 3;
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic compare();
    check("count",    32'(count),        32'(q.size()));
    check("full",     32'(full),         32'(q.size() == DEPTH));
    check("empty",    32'(empty),        32'(q.size() == 0));
    check("rd_valid", 32'(bus.rd_valid), 32'(q.size() != 0));
    check("overflow", 32'(overflow),     32'(m_ovf));
    check("state",    32'(state),        32'(m_state));
    if (q.size() != 0) check("rd_data", 32'(bus.rd_data), 32'(q[0]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic quiet();
    arm           = 1'b0;
    clear         = 1'b0;
    bus.reg_write = 1'b0;
    bus.rd_ready  = 1'b0;
  endtask

  task automatic do_clear();
    quiet();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic arm_for(input logic [7:0] tpc, input logic [4:0] len);
    trig_pc = tpc;
    cap_len = len;
    bus.pc  = ~tpc;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
  endtask

  task automatic event_at(input logic [7:0] p, input logic [7:0] ins, input logic [7:0] res);
    bus.pc        = p;
    bus.instr     = ins;
    bus.result    = res;
    bus.reg_write = 1'b1;
    tick();
    bus.reg_write = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    trig_pc    = 8'h00;
    cap_len    = 5'd0;
    bus.pc     = 8'h00;
    bus.instr  = 8'h00;
    bus.result = 8'h00;
    quiet();
    @(negedge clk);
    tick();
    tick();
    check("rst_rd_data", 32'(bus.rd_data), 32'h0);
    check("rst_state",   32'(state),       32'd0);
    reset = 1'b1;

    // Capture window of three starting at pc 0x04.
    do_clear();
    arm_for(8'h04, 5'd3);
    for (int i = 0; i < 10; i++) event_at(8'(i), 8'($urandom), 8'($urandom));
    check("cap3_state", 32'(state),              32'd3);
    check("cap3_count", 32'(count),              32'd3);
    check("cap3_head",  32'(bus.rd_data[23:16]), 32'h04);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.rd_ready = 1'b0;

    // Unlimited capture into a stalled reader overflows.
    do_clear();
    arm_for(8'h20, 5'd0);
    for (int i = 0; i < 20; i++) event_at(8'h20 + 8'(i), 8'($urandom), 8'($urandom));
    check("ovf_count", 32'(count),              32'd16);
    check("ovf_full",  32'(full),               32'd1);
    check("ovf_flag",  32'(overflow),           32'd1);
    check("ovf_head",  32'(bus.rd_data[23:16]), 32'h20);

    // Full buffer with a simultaneous pop accepts the event.
    do_clear();
    arm_for(8'h40, 5'd0);
    for (int i = 0; i < 16; i++) event_at(8'h40 + 8'(i), 8'($urandom), 8'($urandom));
    bus.rd_ready = 1'b1;
    event_at(8'h77, 8'h11, 8'h22);
    check("fullpop_count", 32'(count),    32'd16);
    check("fullpop_ovf",   32'(overflow), 32'd0);
    for (int i = 0; i < 15; i++) tick();
    bus.rd_ready = 1'b0;
    check("fullpop_tail", 32'(bus.rd_data), 32'h771122);
    check("fullpop_last", 32'(count),       32'd1);

    // Single event into an empty buffer, then pop.
    do_clear();
    arm_for(8'h10, 5'd1);
    event_at(8'h10, 8'hA5, 8'h3C);
    check("single_valid", 32'(bus.rd_valid), 32'd1);
    check("single_data",  32'(bus.rd_data),  32'h10A53C);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("single_empty", 32'(empty), 32'd1);

    // clear wins over a same-cycle event and pop.
    do_clear();
    arm_for(8'h30, 5'd0);
    for (int i = 0; i < 18; i++) event_at(8'h30 + 8'(i), 8'($urandom), 8'($urandom));
    clear         = 1'b1;
    bus.rd_ready  = 1'b1;
    bus.reg_write = 1'b1;
    bus.pc        = 8'h55;
    tick();
    quiet();
    check("clr_count", 32'(count),    32'd0);
    check("clr_ovf",   32'(overflow), 32'd0);
    check("clr_state", 32'(state),    32'd0);

    // Reset mid-capture discards entries and needs a fresh arm.
    do_clear();
    arm_for(8'h50, 5'd0);
    for (int i = 0; i < 7; i++) event_at(8'h50 + 8'(i), 8'($urandom), 8'($urandom));
    check("rst7_count", 32'(count), 32'd7);
    check("rst7_state", 32'(state), 32'd2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst7_after_count", 32'(count),        32'd0);
    check("rst7_after_empty", 32'(empty),        32'd1);
    check("rst7_after_valid", 32'(bus.rd_valid), 32'd0);
    check("rst7_after_data",  32'(bus.rd_data),  32'h0);
    for (int i = 0; i < 5; i++) event_at(8'h50 + 8'(i), 8'($urandom), 8'($urandom));
    check("rst7_noarm_count", 32'(count), 32'd0);
    check("rst7_noarm_state", 32'(state), 32'd0);

    // Randomized segments; cap_len is held steady within each segment.
    for (int s = 0; s < 40; s++) begin
      int rd_pct;
      do_clear();
      cap_len = 5'($urandom_range(0, 20));
      trig_pc = 8'($urandom_range(0, 7));
      rd_pct  = $urandom_range(0, 100);
      for (int c = 0; c < 80; c++) begin
        arm           = ($urandom_range(0, 15) == 0);
        clear         = ($urandom_range(0, 199) == 0);
        reset         = ($urandom_range(0, 299) != 0);
        bus.pc        = 8'($urandom_range(0, 7));
        bus.instr     = 8'($urandom);
        bus.result    = 8'($urandom);
        bus.reg_write = ($urandom_range(0, 3) != 0);
        bus.rd_ready  = ($urandom_range(0, 99) < rd_pct);
        tick();
      end
      reset = 1'b1;
      quiet();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
